uart_rx_ctrl: RTL and testbench

Receive-side sequencer for the UART: consumes the already-synchronized serial line from the 2-FF RX synchronizer and frames it into bytes (8N1, LSB first). It detects start bits, rejects glitches, samples each bit at mid-bit, checks the stop bit, and hands a byte plus a one-cycle valid strobe to the downstream logic (command decoder / FIFO). Framing errors are flagged, and the controller holds off during a line break.

---
 rtl/uart_rx_ctrl.sv | 139 +++++++++++++
 tb/tb_uart_rx_ctrl.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_ctrl.sv
// rtl/uart_rx_ctrl.sv - 8N1 UART receive sequencer with glitch, framing-error and break handling
module uart_rx_ctrl #(
    parameter int CLKS_PER_BIT = 87
) (
    input  logic       i_Clock,
    input  logic       i_Reset,
    input  logic       i_Rx_Data,
    output logic       o_Rx_DV,
    output logic [7:0] o_Rx_Byte,
    output logic       o_Frame_Err,
    output logic       o_Busy
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] HALF = CNT_W'((CLKS_PER_BIT - 1) / 2);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_START      = 3'd1,
        S_DATA       = 3'd2,
        S_STOP       = 3'd3,
        S_CLEANUP    = 3'd4,
        S_BREAK_WAIT = 3'd5
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       byte_q, byte_d;
    logic             dv_q, dv_d;
    logic             err_q, err_d;

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            byte_q  <= '0;
            dv_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            byte_q  <= byte_d;
            dv_q    <= dv_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        byte_d  = byte_q;
        dv_d    = 1'b0;
        err_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                idx_d = '0;
                if (!i_Rx_Data) begin
                    state_d = S_START;
                end
            end

            // Re-check at mid start bit; a line that has returned high was a glitch.
            S_START: begin
                if (cnt_q == HALF) begin
                    cnt_d   = '0;
                    state_d = i_Rx_Data ? S_IDLE : S_DATA;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            S_DATA: begin
                if (cnt_q == LAST) begin
                    cnt_d          = '0;
                    shift_d[idx_q] = i_Rx_Data;
                    if (idx_q == 3'd7) begin
                        idx_d   = '0;
                        state_d = S_STOP;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            // Only a correctly framed byte reaches the output register.
            S_STOP: begin
                if (cnt_q == LAST) begin
                    cnt_d = '0;
                    if (i_Rx_Data) begin
                        byte_d  = shift_q;
                        dv_d    = 1'b1;
                        state_d = S_CLEANUP;
                    end else begin
                        err_d   = 1'b1;
                        state_d = S_BREAK_WAIT;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            S_CLEANUP: begin
                state_d = S_IDLE;
            end

            // Held-low line: one error already flagged, wait for the line to recover.
            S_BREAK_WAIT: begin
                if (i_Rx_Data) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
                idx_d   = '0;
            end
        endcase
    end

    assign o_Rx_DV     = dv_q;
    assign o_Rx_Byte   = byte_q;
    assign o_Frame_Err = err_q;
    assign o_Busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb/tb_uart_rx_ctrl.sv - scoreboard bench for uart_rx_ctrl at CLKS_PER_BIT = 4
module tb_uart_rx_ctrl;

    localparam int C = 4;
    localparam int H = (C - 1) / 2;

    typedef struct {
        logic [7:0] data;
        logic       is_err;
        int         t_exp;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       rx;
    logic       rx_dv;
    logic [7:0] rx_byte;
    logic       frame_err;
    logic       busy;

    exp_t       sb[$];
    int         cyc;
    int         total;
    int         bad;
    logic [7:0] last_good;

    uart_rx_ctrl #(.CLKS_PER_BIT(C)) dut (
        .i_Clock     (clk),
        .i_Reset     (rst),
        .i_Rx_Data   (rx),
        .o_Rx_DV     (rx_dv),
        .o_Rx_Byte   (rx_byte),
        .o_Frame_Err (frame_err),
        .o_Busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard monitor: every strobe must match the head of the queue in value and cycle.
    always @(negedge clk) begin
        exp_t e;
        cyc = cyc + 1;
        if (!rst) begin
            if (rx_dv && frame_err) begin
                total = total + 1;
                bad   = bad + 1;
                $display("FAIL strobe_overlap: dv=%0b err=%0b both high at cycle %0d", rx_dv, frame_err, cyc);
            end
            if (rx_dv || frame_err) begin
                total = total + 1;
                if (sb.size() == 0) begin
                    bad = bad + 1;
                    $display("FAIL unexpected_strobe: dv=%0b err=%0b byte=%02h at cycle %0d, none expected", rx_dv, frame_err, rx_byte, cyc);
                end else begin
                    e = sb.pop_front();
                    if (frame_err !== e.is_err) begin
                        bad = bad + 1;
                        $display("FAIL strobe_kind: err=%0b expected err=%0b", frame_err, e.is_err);
                    end
                    total = total + 1;
                    if (cyc !== e.t_exp) begin
                        bad = bad + 1;
                        $display("FAIL strobe_time: cycle=%0d expected cycle=%0d", cyc, e.t_exp);
                    end
                    total = total + 1;
                    if (e.is_err) begin
                        if (rx_byte !== last_good) begin
                            bad = bad + 1;
                            $display("FAIL byte_held: byte=%02h expected %02h", rx_byte, last_good);
                        end
                    end else begin
                        if (rx_byte !== e.data) begin
                            bad = bad + 1;
                            $display("FAIL rx_byte: byte=%02h expected %02h", rx_byte, e.data);
                        end
                        last_good = e.data;
                    end
                end
            end
        end
    end

    task automatic send_frame(input logic [7:0] b, input logic stop_v);
        exp_t e;
        @(posedge clk);
        #1;
        e.data   = b;
        e.is_err = ~stop_v;
        e.t_exp  = cyc + 1 + 2 + H + 9 * C;
        sb.push_back(e);
        rx = 1'b0;
        repeat (C) @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (C) @(posedge clk);
            #1;
        end
        rx = stop_v;
        repeat (C - 1) @(posedge clk);
    endtask

    task automatic idle(input int n);
        @(posedge clk);
        #1;
        rx = 1'b1;
        repeat (n) @(posedge clk);
    endtask

    task automatic check_drained(input string name);
        total = total + 1;
        if (sb.size() != 0) begin
            bad = bad + 1;
            $display("FAIL %s_drained: %0d strobes still pending, expected 0", name, sb.size());
            sb.delete();
        end
    endtask

    task automatic test_reset;
        #1;
        total = total + 4;
        if (rx_dv !== 1'b0)     begin bad = bad + 1; $display("FAIL reset_dv: %0b expected 0", rx_dv); end
        if (rx_byte !== 8'h00)  begin bad = bad + 1; $display("FAIL reset_byte: %02h expected 00", rx_byte); end
        if (frame_err !== 1'b0) begin bad = bad + 1; $display("FAIL reset_err: %0b expected 0", frame_err); end
        if (busy !== 1'b0)      begin bad = bad + 1; $display("FAIL reset_busy: %0b expected 0", busy); end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (6) @(posedge clk);
        @(negedge clk);
        total = total + 1;
        if (busy !== 1'b0 || rx_dv !== 1'b0) begin
            bad = bad + 1;
            $display("FAIL reset_idle: busy=%0b dv=%0b expected 0 0", busy, rx_dv);
        end
    endtask

    task automatic test_good_byte;
        send_frame(8'hA5, 1'b1);
        @(negedge clk);
        total = total + 1;
        if (rx_dv !== 1'b1 || busy !== 1'b1) begin
            bad = bad + 1;
            $display("FAIL good_t39: dv=%0b busy=%0b expected 1 1", rx_dv, busy);
        end
        @(negedge clk);
        total = total + 1;
        if (busy !== 1'b0 || rx_dv !== 1'b0) begin
            bad = bad + 1;
            $display("FAIL good_t40: busy=%0b dv=%0b expected 0 0", busy, rx_dv);
        end
        idle(4);
        check_drained("good");
    endtask

    task automatic test_back_to_back;
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        idle(6);
        check_drained("b2b");
    endtask

    task automatic test_glitch;
        logic exp_busy [4];
        exp_busy = '{1'b0, 1'b1, 1'b1, 1'b0};
        @(posedge clk);
        #1;
        rx = 1'b0;
        for (int t = 0; t < 4; t++) begin
            @(negedge clk);
            total = total + 1;
            if (busy !== exp_busy[t]) begin
                bad = bad + 1;
                $display("FAIL glitch_busy_t%0d: busy=%0b expected %0b", t, busy, exp_busy[t]);
            end
            if (t == 0) begin
                @(posedge clk);
                #1;
                rx = 1'b1;
            end
        end
        idle(8);
        check_drained("glitch");
    endtask

    task automatic test_frame_error;
        send_frame(8'h55, 1'b0);
        repeat (50) @(posedge clk);
        @(negedge clk);
        total = total + 1;
        if (busy !== 1'b1) begin
            bad = bad + 1;
            $display("FAIL break_busy: busy=%0b expected 1", busy);
        end
        check_drained("ferr");
        idle(3);
        @(negedge clk);
        total = total + 1;
        if (busy !== 1'b0) begin
            bad = bad + 1;
            $display("FAIL break_release: busy=%0b expected 0", busy);
        end
        send_frame(8'h3C, 1'b1);
        idle(6);
        check_drained("after_break");
    endtask

    task automatic test_reset_mid_frame;
        logic [7:0] b;
        b = 8'hF0;
        @(posedge clk);
        #1;
        rx = 1'b0;
        repeat (C) @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            rx = b[i];
            repeat (C) @(posedge clk);
            #1;
        end
        rx = b[4];
        repeat (2) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        total = total + 3;
        if (busy !== 1'b0)     begin bad = bad + 1; $display("FAIL mid_reset_busy: %0b expected 0", busy); end
        if (rx_byte !== 8'h00) begin bad = bad + 1; $display("FAIL mid_reset_byte: %02h expected 00", rx_byte); end
        if (rx_dv !== 1'b0 || frame_err !== 1'b0) begin
            bad = bad + 1;
            $display("FAIL mid_reset_strobes: dv=%0b err=%0b expected 0 0", rx_dv, frame_err);
        end
        last_good = 8'h00;
        @(posedge clk);
        #1;
        rx  = 1'b1;
        rst = 1'b0;
        repeat (5) @(posedge clk);
        send_frame(8'h81, 1'b1);
        idle(6);
        check_drained("mid_reset");
    endtask

    initial begin
        cyc       = 0;
        total     = 0;
        bad       = 0;
        last_good = 8'h00;
        rst       = 1'b1;
        rx        = 1'b1;
        test_reset;
        test_good_byte;
        test_back_to_back;
        test_glitch;
        test_frame_error;
        test_reset_mid_frame;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
